// File: rtl/add_sub_if.sv
// Operand/result bundle for the registered add/subtract unit.
// The master presents operands; the slave (the arithmetic unit) returns the
// registered result and ALU flags one cycle later.
interface add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             out_valid;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, op, A, B,
        input  Result, out_valid, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op, A, B,
        output Result, out_valid, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/add_sub_unit.sv
// Registered two's-complement adder/subtractor with ALU flags.
// Subtraction reuses the adder as A + ~B + 1. The carry chain is a two-level
// carry-lookahead: 4-bit CLA groups, with group generate/propagate feeding a
// lookahead stage across the groups. WIDTH must be a multiple of 4.
module add_sub_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    add_sub_if.slave   bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   c_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG-1:0]    grp_p_s;
    logic [NG:0]      grp_c_s;
    logic             cin_s;
    logic             carry_out_s;
    logic             overflow_s;
    logic             zero_s;

    logic [WIDTH-1:0] result_r;
    logic             out_valid_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             negative_r;

    // Carries into bits 1..3 of a 4-bit group, fully expanded (no ripple).
    function automatic logic [2:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       cin);
        logic c1;
        logic c2;
        logic c3;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return {c3, c2, c1};
    endfunction

    // Group generate of a 4-bit block.
    function automatic logic grp_generate(input logic [3:0] g,
                                          input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Operand conditioning: invert B and inject carry-in for subtract; per-bit G/P.
    always_comb begin
        if (bus.op) begin
            b_eff_s = ~bus.B;
            cin_s   = 1'b1;
        end else begin
            b_eff_s = bus.B;
            cin_s   = 1'b0;
        end
        g_s = bus.A & b_eff_s;
        p_s = bus.A ^ b_eff_s;
    end

    // Group generate/propagate for each 4-bit block.
    always_comb begin
        grp_g_s = '0;
        grp_p_s = '0;
        for (int k = 0; k < NG; k++) begin
            grp_g_s[k] = grp_generate(g_s[4*k +: 4], p_s[4*k +: 4]);
            grp_p_s[k] = &p_s[4*k +: 4];
        end
    end

    // Second-level lookahead: each group carry as a sum of products of group G/P.
    always_comb begin
        logic acc_s;
        logic term_s;
        grp_c_s    = '0;
        grp_c_s[0] = cin_s;
        for (int k = 0; k < NG; k++) begin
            acc_s = cin_s;
            for (int j = 0; j <= k; j++) begin
                acc_s = acc_s & grp_p_s[j];
            end
            for (int j = 0; j <= k; j++) begin
                term_s = grp_g_s[j];
                for (int m = j + 1; m <= k; m++) begin
                    term_s = term_s & grp_p_s[m];
                end
                acc_s = acc_s | term_s;
            end
            grp_c_s[k+1] = acc_s;
        end
    end

    // Bit carries inside each group, the sum, and the combinational flags.
    always_comb begin
        c_s = '0;
        for (int k = 0; k < NG; k++) begin
            c_s[4*k]       = grp_c_s[k];
            c_s[4*k+1 +: 3] = cla4_carries(g_s[4*k +: 4], p_s[4*k +: 4], grp_c_s[k]);
        end
        c_s[WIDTH]  = grp_c_s[NG];
        sum_s       = p_s ^ c_s[WIDTH-1:0];
        carry_out_s = c_s[WIDTH];
        overflow_s  = c_s[WIDTH-1] ^ c_s[WIDTH];
        zero_s      = (sum_s == '0);
    end

    // Output register: reset clears everything, a valid op loads, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= '0;
            out_valid_r <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
        end else if (bus.in_valid) begin
            result_r    <= sum_s;
            out_valid_r <= 1'b1;
            carry_out_r <= carry_out_s;
            overflow_r  <= overflow_s;
            zero_r      <= zero_s;
            negative_r  <= sum_s[WIDTH-1];
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.Result    = result_r;
    assign bus.out_valid = out_valid_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
    assign bus.negative  = negative_r;
endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit: directed vector table, reset cases,
// and a random back-to-back run checked through an expected-result queue.
module tb_add_sub_unit;
    localparam int W = 32;

    typedef struct packed {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
        logic         neg;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    logic valid_q[$];
    exp_t last_exp;

    add_sub_if #(.WIDTH(W)) bus ();

    add_sub_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: 33-bit arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] ext;
        if (op) ext = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else    ext = {1'b0, a} + {1'b0, b};
        e.res   = ext[W-1:0];
        e.carry = ext[W];
        if (op) e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        else    e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        e.zero  = (e.res == '0);
        e.neg   = e.res[W-1];
        return e;
    endfunction

    task automatic compare(input string name, input logic exp_valid, input exp_t e);
        checks++;
        if (bus.out_valid !== exp_valid || bus.Result !== e.res || bus.carry_out !== e.carry ||
            bus.overflow !== e.ovf || bus.zero !== e.zero || bus.negative !== e.neg) begin
            errors++;
            $display("FAIL %s: got v=%b res=%h c=%b o=%b z=%b n=%b, expected v=%b res=%h c=%b o=%b z=%b n=%b",
                     name, bus.out_valid, bus.Result, bus.carry_out, bus.overflow, bus.zero, bus.negative,
                     exp_valid, e.res, e.carry, e.ovf, e.zero, e.neg);
        end
    endtask

    // One clock: drive inputs, queue expectation, clock, then check the registered output.
    task automatic cycle(input string name, input logic v, input logic op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        bus.in_valid = v;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        valid_q.push_back(v);
        if (v) exp_q.push_back(e);
        @(posedge clk);
        #1;
        // Wiggle inputs after the edge; registered outputs must not follow.
        bus.A = ~a;
        bus.op = ~op;
        #1;
        if (valid_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else if (valid_q.pop_front()) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: expected result missing", name);
            end else begin
                last_exp = exp_q.pop_front();
                compare(name, 1'b1, last_exp);
            end
        end else begin
            compare(name, 1'b0, last_exp);
        end
    endtask

    // Reset with in_valid high and live operands: every output must clear.
    task automatic do_reset(input string name);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.A        = 32'hFFFF_FFFF;
        bus.B        = 32'h0000_0001;
        @(posedge clk);
        #1;
        last_exp = '0;
        exp_q.delete();
        valid_q.delete();
        compare(name, 1'b0, last_exp);
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        logic v, op;
        logic [W-1:0] a, b;

        vecs[0] = '{1'b0, 32'd5,          32'd7,          32'd12,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,           1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,   1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'd5,          32'd7,          32'hFFFF_FFFE,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h1234_5678,  32'h1234_5678,  32'd0,           1'b1, 1'b0, 1'b1, 1'b0};

        checks       = 0;
        errors       = 0;
        last_exp     = '0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset_with_valid");

        // Directed vectors, back to back.
        for (int i = 0; i < 6; i++) begin
            e.res   = vecs[i].res;
            e.carry = vecs[i].carry;
            e.ovf   = vecs[i].ovf;
            e.zero  = vecs[i].zero;
            e.neg   = vecs[i].neg;
            cycle($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        // Idle cycles: out_valid drops, result and flags hold the last vector.
        cycle("hold1", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1, '0);
        cycle("hold2", 1'b0, 1'b1, 32'h0, 32'h5, '0);

        // Reset overrides a pending valid op.
        cycle("pre_reset_op", 1'b1, 1'b0, 32'd100, 32'd23, model(1'b0, 32'd100, 32'd23));
        do_reset("reset_mid_stream");
        cycle("post_reset_idle", 1'b0, 1'b0, 32'd1, 32'd1, '0);

        // Random back-to-back traffic with edge-biased operands.
        for (int i = 0; i < 1000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                2:       a = 32'h7FFF_FFFF;
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 4))
                0:       b = a;
                1:       b = 32'd1;
                2:       b = 32'h0000_0000;
                default: b = $urandom();
            endcase
            cycle("random", v, op, a, b, model(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
